// File: rtl/perf_counter_bank.sv
// Performance-counter bank: NCH event counters gated by a run/halt FSM, with sticky
// overflow flags and a snapshot bank for stable readout. Define PERF_SATURATE_EN to saturate instead of wrap.
module perf_counter_bank #(
  parameter int WIDTH = 16,
  parameter int NCH   = 4,
  parameter int SELW  = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  input  logic [NCH-1:0]   events,
  input  logic             snap,
  input  logic [SELW-1:0]  sel,
  output logic [WIDTH-1:0] rdata,
  output logic [NCH-1:0]   ovf,
  output logic             running,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_HALTED = 2'b10,
    ST_BAD    = 2'b11
  } state_t;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] live_q [NCH];
  logic [WIDTH-1:0] snap_q [NCH];
  logic [NCH-1:0]   ovf_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Priority clear > stop > start; the unused encoding recovers to IDLE.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:   if (start) state_d = ST_RUN;
        ST_RUN:    if (stop)  state_d = ST_HALTED;
        ST_HALTED: if (start) state_d = ST_RUN;
        default:              state_d = ST_IDLE;
      endcase
    end
  end

  // Counting keys off the pre-edge state, so the stop edge counts and the start edge does not.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        live_q[i] <= '0;
        snap_q[i] <= '0;
      end
      ovf_q <= '0;
    end else if (clear) begin
      for (int i = 0; i < NCH; i++) begin
        live_q[i] <= '0;
        snap_q[i] <= '0;
      end
      ovf_q <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (snap) snap_q[i] <= live_q[i];
        if (state_q == ST_RUN && events[i]) begin
          if (live_q[i] == {WIDTH{1'b1}}) begin
            ovf_q[i] <= 1'b1;
`ifdef PERF_SATURATE_EN
            live_q[i] <= live_q[i];
`else
            live_q[i] <= '0;
`endif
          end else begin
            live_q[i] <= live_q[i] + ONE;
          end
        end
      end
    end
  end

  // Pure mux; select values with no channel behind them read as zero.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < NCH; i++) begin
      if (sel == SELW'(i)) rdata = snap_q[i];
    end
  end

  assign ovf     = ovf_q;
  assign running = (state_q == ST_RUN);
  assign state   = state_q;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed bench for perf_counter_bank: a 16-bit/4-channel instance and a 4-bit/3-channel
// instance share control inputs; expected readouts are hand-computed.
module tb_perf_counter_bank;

  logic        clock;
  logic        reset;
  logic        start, stop, clear, snap;
  logic [1:0]  sel;
  logic [3:0]  ev4;
  logic [2:0]  ev3;

  logic [15:0] rdata_m;
  logic [3:0]  ovf_m;
  logic        running_m;
  logic [1:0]  state_m;

  logic [3:0]  rdata_s;
  logic [2:0]  ovf_s;
  logic        running_s;
  logic [1:0]  state_s;

  logic [31:0] exp_q[$];
  int          n_checks;
  int          n_fail;

  perf_counter_bank #(.WIDTH(16), .NCH(4), .SELW(2)) dut_m (
    .clock(clock), .reset(reset), .start(start), .stop(stop), .clear(clear),
    .events(ev4), .snap(snap), .sel(sel),
    .rdata(rdata_m), .ovf(ovf_m), .running(running_m), .state(state_m)
  );

  perf_counter_bank #(.WIDTH(4), .NCH(3), .SELW(2)) dut_s (
    .clock(clock), .reset(reset), .start(start), .stop(stop), .clear(clear),
    .events(ev3), .snap(snap), .sel(sel),
    .rdata(rdata_s), .ovf(ovf_s), .running(running_s), .state(state_s)
  );

  // Clock and reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Driver tasks: inputs change at the falling edge, outputs are sampled there too.
  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_clear();
    clear = 1'b1; tick(); clear = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic do_snap();
    snap = 1'b1; tick(); snap = 1'b0;
  endtask

  // Run n counting edges, with stop asserted on the last one.
  task automatic run_and_stop(input int n);
    for (int k = 1; k <= n; k++) begin
      stop = (k == n);
      tick();
    end
    stop = 1'b0;
  endtask

  // Scoreboard readers: pop the next expected snapshot value for the selected channel.
  task automatic check_rd_m(input string tag, input logic [1:0] s);
    logic [31:0] e;
    sel = s; #1;
    e = exp_q.pop_front();
    check_eq(tag, {16'd0, rdata_m}, e);
  endtask

  task automatic check_rd_s(input string tag, input logic [1:0] s);
    logic [31:0] e;
    sel = s; #1;
    e = exp_q.pop_front();
    check_eq(tag, {28'd0, rdata_s}, e);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    start = 0; stop = 0; clear = 0; snap = 0; sel = 0; ev4 = 0; ev3 = 0;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    check_eq("rst_state", {30'd0, state_m}, 32'd0);
    check_eq("rst_running", {31'd0, running_m}, 32'd0);
    check_eq("rst_rdata", {16'd0, rdata_m}, 32'd0);
    check_eq("rst_ovf", {28'd0, ovf_m}, 32'd0);
    reset = 1'b0;

    // Cycle count: start at edge 1, stop at edge 11, snap at edge 12
    ev4 = 4'b0001;
    do_start();
    check_eq("start_running", {31'd0, running_m}, 32'd1);
    repeat (9) tick();
    stop = 1'b1; tick(); stop = 1'b0;
    check_eq("stop_running", {31'd0, running_m}, 32'd0);
    check_eq("stop_state", {30'd0, state_m}, 32'd2);
    do_snap();
    exp_q.push_back(32'd10);
    check_rd_m("cyc_count", 2'd0);
    check_eq("cyc_ovf", {28'd0, ovf_m}, 32'd0);

    // Per-channel gating: event[1] on alternate edges over 20 RUN edges
    do_clear();
    check_eq("clr_state", {30'd0, state_m}, 32'd0);
    exp_q.push_back(32'd0);
    check_rd_m("clr_rdata", 2'd0);
    do_start();
    for (int k = 0; k < 20; k++) begin
      ev4 = {2'b00, (k % 2 == 0), 1'b1};
      ev3 = {1'b0, (k % 2 == 0), 1'b0};
      stop = (k == 19);
      tick();
    end
    stop = 1'b0; ev4 = 4'b0000; ev3 = 3'b000;
    do_snap();
    exp_q.push_back(32'd20); exp_q.push_back(32'd10);
    exp_q.push_back(32'd0);  exp_q.push_back(32'd0);
    check_rd_m("gate_ch0", 2'd0);
    check_rd_m("gate_ch1", 2'd1);
    check_rd_m("gate_ch2", 2'd2);
    check_rd_m("gate_ch3", 2'd3);
    exp_q.push_back(32'd10); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    check_rd_s("gate_s_ch1", 2'd1);
    check_rd_s("gate_s_ch2", 2'd2);
    check_rd_s("gate_s_sel3", 2'd3);

    // Wrap / saturation on the 4-bit instance: 17 events on channel 0
    do_clear();
    do_start();
    ev4 = 4'b0001; ev3 = 3'b001;
    for (int k = 1; k <= 17; k++) begin
      stop = (k == 17);
      tick();
      if (k == 15) check_eq("ovf_before_wrap", {29'd0, ovf_s}, 32'd0);
      if (k == 16) check_eq("ovf_at_wrap", {29'd0, ovf_s}, 32'd1);
    end
    stop = 1'b0;
    do_snap();
`ifdef PERF_SATURATE_EN
    exp_q.push_back(32'hF);
`else
    exp_q.push_back(32'd1);
`endif
    check_rd_s("wrap_s_ch0", 2'd0);
    exp_q.push_back(32'd17);
    check_rd_m("wrap_m_ch0", 2'd0);
    check_eq("wrap_ovf_s", {29'd0, ovf_s}, 32'd1);
    check_eq("wrap_ovf_m", {28'd0, ovf_m}, 32'd0);

    // Snap coinciding with an increment from 5
    do_clear();
    do_start();
    ev4 = 4'b0001; ev3 = 3'b000;
    repeat (5) tick();
    do_snap();
    exp_q.push_back(32'd5);
    check_rd_m("snap_old", 2'd0);
    ev4 = 4'b0000;
    snap = 1'b1; stop = 1'b1; tick(); snap = 1'b0; stop = 1'b0;
    exp_q.push_back(32'd6);
    check_rd_m("snap_live", 2'd0);
    check_eq("snap_state", {30'd0, state_m}, 32'd2);

    // clear with snap: clear wins
    clear = 1'b1; snap = 1'b1; tick(); clear = 1'b0; snap = 1'b0;
    exp_q.push_back(32'd0);
    check_rd_m("clrsnap_rdata", 2'd0);
    check_eq("clrsnap_state", {30'd0, state_m}, 32'd0);

    // start together with stop while in RUN
    do_start();
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    check_eq("startstop_state", {30'd0, state_m}, 32'd2);

    // Resume: halt at 7, restart, 3 more -> 10
    do_clear();
    ev4 = 4'b0001; ev3 = 3'b001;
    do_start();
    run_and_stop(7);
    do_snap();
    exp_q.push_back(32'd7);
    check_rd_m("resume_7", 2'd0);
    do_start();
    run_and_stop(3);
    do_snap();
    exp_q.push_back(32'd10); exp_q.push_back(32'd10);
    check_rd_m("resume_10", 2'd0);
    check_rd_s("resume_s_10", 2'd0);

    // Asynchronous reset between edges while running
    do_start();
    check_eq("pre_rst_running", {31'd0, running_m}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check_eq("arst_state", {30'd0, state_m}, 32'd0);
    check_eq("arst_running", {31'd0, running_m}, 32'd0);
    check_eq("arst_rdata", {16'd0, rdata_m}, 32'd0);
    check_eq("arst_rdata_s", {28'd0, rdata_s}, 32'd0);
    check_eq("arst_ovf", {28'd0, ovf_m}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    ev4 = 4'b0000; ev3 = 3'b000;

    // Final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/perf_counter_bank.md
# perf_counter_bank

Parametrised performance-counter bank for the multicycle processor. It replaces the single hard-wired 16-bit cycle counter with NCH independent event counters of WIDTH bits, gated by a run/halt state machine. Each counter has a sticky overflow flag. A snapshot bank drives the HEX display and LEDs so the readout stays stable while counting continues. It sits beside the control FSM: it takes start/stop/event strobes from the FSM and feeds the HEX display muxes.

## Interface
Parameters:
- WIDTH, 16, bits per counter (2..32)
- NCH, 4, number of event channels (1..8)
- SELW, 2, width of channel select; must be ≥1 and 2^SELW ≥ NCH

Ports:
- clock  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears everything
- start  in  1  level sampled each edge; IDLE/HALTED -> RUN
- stop   in  1  level sampled each edge; RUN -> HALTED
- clear  in  1  synchronous clear of counters, snapshots and ovf; state -> IDLE
- event  in  NCH  per-channel increment request (channel 0 normally tied 1 = cycle count)
- snap   in  1  copy all live counters into the snapshot bank
- sel    in  SELW  readout channel select
- rdata  out WIDTH  snapshot[sel]; combinational; 0 if sel ≥ NCH
- ovf    out NCH  sticky per-channel overflow flags
- running out 1  high while state == RUN
- state  out 2  FSM state: IDLE=2'b00, RUN=2'b01, HALTED=2'b10

## Operation
- Reset: state=IDLE, all live counters=0, all snapshots=0, ovf=0, running=0, rdata=0.
- FSM transitions, evaluated at each edge with priority clear > stop > start:
  - IDLE: start -> RUN.
  - RUN: stop -> HALTED.
  - HALTED: start -> RUN (resumes; counters keep their values).
  - Any state: clear -> IDLE.
  - Encoding 2'b11 is unreachable; if it ever occurs, the next edge goes to IDLE.
- Counting: at an edge, live[i] increments by 1 iff the pre-edge state is RUN, event[i]=1 and clear=0.
  - The stop edge still counts, because the state was RUN before that edge.
  - The start edge does not count.
- Arithmetic is unsigned modulo 2^WIDTH. An increment attempted at all-ones sets ovf[i]=1, which stays set until clear or reset.
- Snapshot: when snap=1 at an edge, snapshot[i] takes the pre-edge live[i] for every channel.
  - If snap coincides with an increment, the snapshot holds the old value.
  - If snap coincides with clear, clear wins and the snapshots become 0.
- rdata is a pure mux of the snapshot bank. A change of sel is visible in the same cycle, with no register stage.
- Reset asserted mid-operation: all state and outputs return to their reset values immediately, without waiting for a clock edge.

## Timing
- start at edge k: running=1 after edge k; the first counted event is the one sampled at edge k+1.
- stop at edge m: the event at edge m is counted; running=0 after edge m.
- start and stop at the same edge while in RUN: the state goes to HALTED (stop has priority).
- Counter-to-snapshot latency: 1 edge after snap. snapshot-to-rdata: 0 cycles.
- ovf[i] rises on the same edge as the wrap (or the saturating hold).
- clear is one-cycle effective: it is synchronous and takes effect at the next edge.

## Configuration
- PERF_SATURATE_EN defined: live[i] holds at all-ones and does not wrap. ovf[i] is set on the first increment attempted at all-ones.
- PERF_SATURATE_EN undefined (default): all-ones wraps to 0 and ovf[i] is set on that edge.
- The rest of the behaviour is identical in both builds.

## Test plan
- Cycle count: WIDTH=16, NCH=4, event=4'b0001. Reset; start at edge 1; stop at edge 11; snap at edge 12; sel=0 -> rdata=16'd10, state=2'b10, ovf=0.
- Per-channel gating: during the RUN state, event[1] toggles high on alternate cycles for 20 edges, event[2] stays 0. Snap -> snapshot[1]=10, snapshot[2]=0. Select sel=3 with NCH=3 -> rdata=0.
- Wrap / saturation at WIDTH=4, 17 events on channel 0:
  - Default build: rdata=1, ovf[0]=1.
  - PERF_SATURATE_EN build: rdata=4'hF, ovf[0]=1.
- Simultaneous events:
  - Snap on the same edge as an increment from 5 -> snapshot=5, live=6.
  - clear together with snap -> all snapshots=0, state=IDLE.
  - start together with stop in RUN -> HALTED.
- Resume and reset: halt at count 7, start again, count 3 more -> 10. Assert reset between edges -> rdata=0, ovf=0, state=IDLE, with no clock edge needed.
